// File: rtl/shift_sequencer_if.sv
// Request/response bundle for the shift sequencer.
// The master drives requests and the response ready; the slave is the sequencer.
interface shift_sequencer_if #(
  parameter int N = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_op;
  logic [N-1:0]         req_data;
  logic [$clog2(N)-1:0] req_shamt;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [N-1:0]         resp_data;
  logic                 busy;

  modport master (
    output req_valid, req_op, req_data, req_shamt, resp_ready,
    input  req_ready, resp_valid, resp_data, busy
  );

  modport slave (
    input  req_valid, req_op, req_data, req_shamt, resp_ready,
    output req_ready, resp_valid, resp_data, busy
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: applies at most STEP bits of shift per clock until shamt is consumed.
// Define SHIFT_SEQ_ROT_EN to build ROR for op 11; otherwise op 11 behaves as SLL.
module shift_sequencer #(
  parameter int N    = 32,
  parameter int STEP = 8
) (
  input  logic               clk,
  input  logic               rst,
  shift_sequencer_if.slave   bus
);
  localparam int W  = $clog2(N);
  localparam int W1 = W + 1;
  localparam int SW = $clog2(STEP) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t          state_r;
  logic [1:0]      op_r;
  logic [N-1:0]    data_r;
  logic [W-1:0]    rem_r;
  logic            req_ready_r;
  logic            resp_valid_r;
  logic            busy_r;
  logic [N-1:0]    resp_data_r;

  logic [SW-1:0]   step_s;
  logic [W-1:0]    rem_next_s;
  logic [N-1:0]    shifted_s;

  // One step of the selected shift; the SRA fill tracks the current MSB each step.
  function automatic logic [N-1:0] shift_step(input logic [N-1:0] d,
                                              input logic [1:0]   op,
                                              input logic [SW-1:0] s);
    logic [N-1:0] r;
`ifdef SHIFT_SEQ_ROT_EN
    logic [2*N-1:0] rot;
    rot = {d, d} >> s;
`endif
    r = d;
    case (op)
      2'b00:   r = d << s;
      2'b01:   r = d >> s;
      2'b10:   r = $signed(d) >>> s;
`ifdef SHIFT_SEQ_ROT_EN
      2'b11:   r = rot[N-1:0];
`else
      2'b11:   r = d << s;
`endif
      default: r = d << s;
    endcase
    return r;
  endfunction

  // Step size is min(rem, STEP); the compare is widened so STEP == N still fits.
  always_comb begin
    step_s     = ({1'b0, rem_r} >= W1'(STEP)) ? SW'(STEP) : SW'(rem_r);
    rem_next_s = rem_r - W'(step_s);
    shifted_s  = shift_step(data_r, op_r, step_s);
  end

  // Sequencer FSM with registered handshake and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      op_r         <= 2'b00;
      data_r       <= {N{1'b0}};
      rem_r        <= {W{1'b0}};
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      resp_data_r  <= {N{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.req_valid && req_ready_r) begin
            op_r        <= bus.req_op;
            data_r      <= bus.req_data;
            rem_r       <= bus.req_shamt;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            if (bus.req_shamt == {W{1'b0}}) begin
              state_r      <= ST_DONE;
              resp_valid_r <= 1'b1;
              resp_data_r  <= bus.req_data;
            end else begin
              state_r <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          data_r <= shifted_s;
          rem_r  <= rem_next_s;
          if (rem_next_s == {W{1'b0}}) begin
            state_r      <= ST_DONE;
            resp_valid_r <= 1'b1;
            resp_data_r  <= shifted_s;
          end
        end
        ST_DONE: begin
          // resp_data_r is left alone so the last result stays visible in IDLE.
          if (bus.resp_ready) begin
            state_r      <= ST_IDLE;
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            req_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          resp_valid_r <= 1'b0;
          busy_r       <= 1'b0;
          req_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_data  = resp_data_r;
  assign bus.busy       = busy_r;
endmodule
